// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcode/func fields,
// ALU op codes, datapath select codes and the decoded instruction-class record.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SRA = 6'b000011;
    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;

    // Don't-care bits of the ALU codes are tied to 0.
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [1:0] ASB_REG  = 2'b00;
    localparam logic [1:0] ASB_FOUR = 2'b01;
    localparam logic [1:0] ASB_IMM  = 2'b10;
    localparam logic [1:0] ASB_BR   = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_RA     = 2'b10;
    localparam logic [1:0] PCS_JADDR  = 2'b11;

    typedef struct packed {
        logic rtype;
        logic itype_alu;
        logic load;
        logic store;
        logic branch_eq;
        logic branch_ne;
        logic jump;
        logic jal;
        logic jr;
        logic shift;
        logic illegal;
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/func decode into instruction-class flags, EXE-step ALU code
// and immediate sign-extension; zero latency, no handshake.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    output iclass_t    cls_o,
    output logic [3:0] aluc_o,
    output logic       sext_o
);

    always_comb begin
        cls_o  = '0;
        aluc_o = ALUC_ADD;
        sext_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                cls_o.rtype = 1'b1;
                case (func_i)
                    F_ADD: aluc_o = ALUC_ADD;
                    F_SUB: aluc_o = ALUC_SUB;
                    F_AND: aluc_o = ALUC_AND;
                    F_OR:  aluc_o = ALUC_OR;
                    F_XOR: aluc_o = ALUC_XOR;
                    F_SLL: begin aluc_o = ALUC_SLL; cls_o.shift = 1'b1; end
                    F_SRL: begin aluc_o = ALUC_SRL; cls_o.shift = 1'b1; end
                    F_SRA: begin aluc_o = ALUC_SRA; cls_o.shift = 1'b1; end
                    F_JR:  begin cls_o.rtype = 1'b0; cls_o.jr = 1'b1; end
                    default: begin cls_o.rtype = 1'b0; cls_o.illegal = 1'b1; end
                endcase
            end
            OP_ADDI: begin cls_o.itype_alu = 1'b1; aluc_o = ALUC_ADD; sext_o = 1'b1; end
            OP_ANDI: begin cls_o.itype_alu = 1'b1; aluc_o = ALUC_AND; end
            OP_ORI:  begin cls_o.itype_alu = 1'b1; aluc_o = ALUC_OR;  end
            OP_XORI: begin cls_o.itype_alu = 1'b1; aluc_o = ALUC_XOR; end
            OP_LUI:  begin cls_o.itype_alu = 1'b1; aluc_o = ALUC_LUI; end
            OP_LW:   begin cls_o.load      = 1'b1; sext_o = 1'b1; end
            OP_SW:   begin cls_o.store     = 1'b1; sext_o = 1'b1; end
            OP_BEQ:  begin cls_o.branch_eq = 1'b1; aluc_o = ALUC_SUB; sext_o = 1'b1; end
            OP_BNE:  begin cls_o.branch_ne = 1'b1; aluc_o = ALUC_SUB; sext_o = 1'b1; end
            OP_J:    cls_o.jump = 1'b1;
            OP_JAL:  cls_o.jal  = 1'b1;
            default: cls_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle control FSM (IF/ID/EXE/MEM/WB) for a shared-memory MIPS datapath.
// Outputs are combinational from state and inputs; IF and MEM stall on mem_ready.
module mc_cu
    import mc_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       regrt,
    output logic       m2reg,
    output logic       shift,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] aluc,
    output logic [1:0] pcsource,
    output logic       jal,
    output logic       sext,
    output logic [2:0] state
);

    state_e     state_q, state_d;
    iclass_t    cls;
    logic [3:0] exe_aluc;
    logic       wpc_d, wir_d, wmem_d, wreg_d;

    mc_decode u_decode (
        .op_i   (op),
        .func_i (func),
        .cls_o  (cls),
        .aluc_o (exe_aluc),
        .sext_o (sext)
    );

    always_ff @(posedge clock) begin
        if (!resetn) state_q <= S_IF;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        wpc_d    = 1'b0;
        wir_d    = 1'b0;
        wmem_d   = 1'b0;
        wreg_d   = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        shift    = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = ASB_REG;
        aluc     = ALUC_ADD;
        pcsource = PCS_ALU;
        jal      = 1'b0;
        case (state_q)
            S_IF: begin
                alusrcb = ASB_FOUR;
                if (mem_ready) begin
                    wir_d   = 1'b1;
                    wpc_d   = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                // Branch target is computed here and parked in ALU-out for EXE.
                alusrcb = ASB_BR;
                state_d = S_EXE;
                if (cls.jump || cls.jal) begin
                    wpc_d    = 1'b1;
                    pcsource = PCS_JADDR;
                    wreg_d   = cls.jal;
                    jal      = cls.jal;
                    state_d  = S_IF;
                end else if (cls.jr) begin
                    wpc_d    = 1'b1;
                    pcsource = PCS_RA;
                    state_d  = S_IF;
                end else if (cls.illegal) begin
                    state_d = S_IF;
                end
            end
            S_EXE: begin
                alusrca = 1'b1;
                aluc    = exe_aluc;
                if (cls.branch_eq || cls.branch_ne) begin
                    alusrcb = ASB_REG;
                    if ((cls.branch_eq && zero) || (cls.branch_ne && !zero)) begin
                        wpc_d    = 1'b1;
                        pcsource = PCS_ALUOUT;
                    end
                    state_d = S_IF;
                end else if (cls.load || cls.store) begin
                    alusrcb = ASB_IMM;
                    state_d = S_MEM;
                end else if (cls.rtype) begin
                    alusrcb = ASB_REG;
                    shift   = cls.shift;
                    state_d = S_WB;
                end else begin
                    alusrcb = ASB_IMM;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                iord   = 1'b1;
                wmem_d = cls.store;
                if (mem_ready) state_d = cls.store ? S_IF : S_WB;
            end
            S_WB: begin
                wreg_d  = 1'b1;
                regrt   = cls.itype_alu || cls.load;
                m2reg   = cls.load;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    // Reset must never let a write escape, even from mid-instruction states.
    assign wpc   = wpc_d  & resetn;
    assign wir   = wir_d  & resetn;
    assign wmem  = wmem_d & resetn;
    assign wreg  = wreg_d & resetn;
    assign state = state_q;

endmodule
